div_iter: RTL and testbench

Parametrised iterative integer divider for the execute stage, generalising the fixed 32-bit unit. It performs signed or unsigned division of two WIDTH-bit operands, producing one quotient bit per cycle. It returns a packed {remainder, quotient} with a one-cycle done pulse. It supports cancellation at any point, defines divide-by-zero and overflow results, and has optional leading-zero early termination.

---
 rtl/div_iter.sv | 218 +++++++++++++++++++++
 tb/tb_div_iter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider, one quotient bit per cycle.
// Ports:
//   clk, rst (async, active-high), start, cancel, signed_op,
//   reg1_i (dividend), reg2_i (divisor),
//   result {remainder, quotient}, done (1-cycle pulse), busy.
// Optional build macro DIV_EARLY_TERM_EN: skip the leading zeros of
// the dividend magnitude to shorten latency (results are unchanged).
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               cancel,
    input  logic               signed_op,
    input  logic [WIDTH-1:0]   reg1_i,
    input  logic [WIDTH-1:0]   reg2_i,
    output logic [2*WIDTH-1:0] result,
    output logic               done,
    output logic               busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIN
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_sgn;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_dvs;
    logic [CW-1:0]      r_cnt;
    logic               r_qneg;
    logic               r_rneg;
    logic               r_nofix;
    logic [2*WIDTH-1:0] r_result;
    logic               r_done;

    logic               w_s1;
    logic               w_s2;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic               w_b_zero;
    logic               w_a_zero;
    logic [WIDTH-1:0]   w_dvd_init;
    logic [CW-1:0]      w_cnt_init;
    logic [WIDTH:0]     w_trial;
    logic               w_qbit;
    logic [WIDTH-1:0]   w_rem_nx;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    // Operand magnitudes; sign bits only count for signed operations.
    assign w_s1     = r_sgn & r_a[WIDTH-1];
    assign w_s2     = r_sgn & r_b[WIDTH-1];
    assign w_abs_a  = w_s1 ? -r_a : r_a;
    assign w_abs_b  = w_s2 ? -r_b : r_b;
    assign w_b_zero = (r_b == '0);

`ifdef DIV_EARLY_TERM_EN
    logic [CW-1:0] w_lz;

    // Leading-zero count: the highest set bit wins (scanned last).
    always_comb begin
        w_lz = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (w_abs_a[i]) begin
                w_lz = CW'(WIDTH - 1 - i);
            end
        end
    end

    assign w_a_zero   = (w_abs_a == '0);
    assign w_dvd_init = w_abs_a << w_lz;
    assign w_cnt_init = CW'(WIDTH) - w_lz;
`else
    assign w_a_zero   = 1'b0;
    assign w_dvd_init = w_abs_a;
    assign w_cnt_init = CW'(WIDTH);
`endif

    // Trial subtract on the shifted partial remainder. The remainder is
    // always below the divisor, so the shifted value fits in WIDTH+1 bits
    // and the top bit of the difference is a clean borrow flag.
    assign w_trial  = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_dvs};
    assign w_qbit   = ~w_trial[WIDTH];
    assign w_rem_nx = w_qbit ? w_trial[WIDTH-1:0]
                             : {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};

    // Sign fix is suppressed for divide-by-zero so raw values pass through.
    assign w_quo_fix = (r_qneg & ~r_nofix) ? -r_quo : r_quo;
    assign w_rem_fix = (r_rneg & ~r_nofix) ? -r_rem : r_rem;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && !cancel) begin
                    w_next = S_PREP;
                end
            end
            S_PREP: begin
                if (cancel) begin
                    w_next = S_IDLE;
                end else if (w_b_zero || w_a_zero) begin
                    w_next = S_FIN;
                end else begin
                    w_next = S_CALC;
                end
            end
            S_CALC: begin
                if (cancel) begin
                    w_next = S_IDLE;
                end else if (r_cnt == CW'(1)) begin
                    w_next = S_FIN;
                end
            end
            S_FIN: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sgn    <= 1'b0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvs    <= '0;
            r_cnt    <= '0;
            r_qneg   <= 1'b0;
            r_rneg   <= 1'b0;
            r_nofix  <= 1'b0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !cancel) begin
                        r_a   <= reg1_i;
                        r_b   <= reg2_i;
                        r_sgn <= signed_op;
                    end
                end
                S_PREP: begin
                    r_qneg <= w_s1 ^ w_s2;
                    r_rneg <= w_s1;
                    r_dvs  <= w_abs_b;
                    if (w_b_zero) begin
                        r_quo   <= '1;
                        r_rem   <= r_a;
                        r_nofix <= 1'b1;
                        r_cnt   <= '0;
                    end else if (w_a_zero) begin
                        r_quo   <= '0;
                        r_rem   <= '0;
                        r_nofix <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_quo   <= w_dvd_init;
                        r_rem   <= '0;
                        r_nofix <= 1'b0;
                        r_cnt   <= w_cnt_init;
                    end
                end
                S_CALC: begin
                    if (!cancel) begin
                        r_quo <= {r_quo[WIDTH-2:0], w_qbit};
                        r_rem <= w_rem_nx;
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_FIN: begin
                    if (!cancel) begin
                        r_result <= {w_rem_fix, w_quo_fix};
                        r_done   <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs; PREP is not reported busy (busy starts the edge after accept).
    always_comb begin
        busy   = (r_state == S_CALC) || (r_state == S_FIN);
        done   = r_done;
        result = r_result;
    end

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: randomized and directed scoreboard bench for div_iter.
module tb_div_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        cancel = 1'b0;
    logic        signed_op = 1'b0;
    logic [31:0] reg1_i = '0;
    logic [31:0] reg2_i = '0;
    logic [63:0] result;
    logic        done;
    logic        busy;

    div_iter #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cancel    (cancel),
        .signed_op (signed_op),
        .reg1_i    (reg1_i),
        .reg2_i    (reg2_i),
        .result    (result),
        .done      (done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        int          at;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [63:0] last_res = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer arithmetic with the stated corner rules.
    function automatic logic [63:0] model(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic s);
        longint sa, sb;
        logic [31:0] qq, rr;
        if (b == 0) begin
            qq = '1;
            rr = a;
        end else if (!s) begin
            qq = a / b;
            rr = a % b;
        end else begin
            sa = $signed(a);
            sb = $signed(b);
            qq = 32'(sa / sb);
            rr = 32'(sa % sb);
        end
        return {rr, qq};
    endfunction

    function automatic int latency(input logic [31:0] a,
                                   input logic [31:0] b,
                                   input logic s);
        logic [31:0] mag;
        int nb;
        if (b == 0) return 2;
        mag = (s && a[31]) ? -a : a;
        nb = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) nb = i + 1;
`ifdef DIV_EARLY_TERM_EN
        if (mag == 0) return 2;
        return nb + 2;
`else
        return 34 + 0 * nb;
`endif
    endfunction

    task automatic push(input logic [31:0] a, input logic [31:0] b,
                        input logic s);
        exp_t e;
        e.res = model(a, b, s);
        e.at  = cyc + 1 + latency(a, b, s);
        q.push_back(e);
    endtask

    // Called just after a negedge with the DUT idle.
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic s);
        reg1_i = a;
        reg2_i = b;
        signed_op = s;
        start = 1'b1;
        push(a, b, s);
        @(negedge clk);
        start = 1'b0;
        reg1_i = $urandom;
        reg2_i = $urandom;
        signed_op = 1'($urandom);
    endtask

    task automatic drain;
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d required=0", q.size());
            q.delete();
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Monitor: every done pops one expectation and checks value and timing.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL spurious_done actual=1 required=0 at %0d", cyc);
            end else begin
                e = q.pop_front();
                if (result !== e.res) begin
                    errors++;
                    $display("FAIL result actual=%h required=%h",
                             result, e.res);
                end
                checks++;
                if (cyc != e.at) begin
                    errors++;
                    $display("FAIL done_edge actual=%0d required=%0d",
                             cyc, e.at);
                end
                last_res = e.res;
            end
        end
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int L, n, cedge;
        logic [31:0] a, b;
        logic s;

        repeat (3) @(negedge clk);
        chk("reset_result", result, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // 100 / 7 with a busy-window check on every cycle.
        L = latency(32'd100, 32'd7, 1'b0);
        reg1_i = 32'd100;
        reg2_i = 32'd7;
        signed_op = 1'b0;
        start = 1'b1;
        push(32'd100, 32'd7, 1'b0);
        for (int k = 0; k <= L; k++) begin
            @(negedge clk);
            start = 1'b0;
            chk("busy_window", {63'd0, busy},
                {63'd0, (k >= 1 && k <= L - 1)});
        end
        drain();
        chk("res_100_7", last_res, {32'd2, 32'd14});

        issue(32'hFFFF_FFF9, 32'd2, 1'b1); drain();
        issue(32'd7, 32'hFFFF_FFFE, 1'b1); drain();
        issue(32'h1234, 32'd0, 1'b0); drain();
        issue(32'h1234, 32'd0, 1'b1); drain();
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1); drain();
        chk("ovf_signed", last_res, {32'd0, 32'h8000_0000});
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0); drain();
        issue(32'd5, 32'd1, 1'b0); drain();
        issue(32'd0, 32'd3, 1'b0); drain();

        // Cancel mid-calculation, then restart next cycle.
`ifdef DIV_EARLY_TERM_EN
        cedge = 5;
`else
        cedge = 10;
`endif
        reg1_i = 32'd100;
        reg2_i = 32'd7;
        signed_op = 1'b0;
        start = 1'b1;
        for (int k = 0; k <= cedge + 1; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == cedge) cancel = 1'b1;
        end
        cancel = 1'b0;
        chk("cancel_busy", {63'd0, busy}, 64'd0);
        chk("cancel_hold", result, last_res);
        issue(32'd9, 32'd3, 1'b0); drain();
        chk("after_cancel", last_res, {32'd0, 32'd3});

        // start with cancel in IDLE is ignored.
        reg1_i = 32'd50;
        reg2_i = 32'd5;
        start = 1'b1;
        cancel = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cancel = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("ign_busy", {63'd0, busy}, 64'd0);
        end

        // Back-to-back: new start in the done cycle.
        issue(32'd1000, 32'd9, 1'b0);
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        issue(32'hDEAD_BEEF, 32'd17, 1'b1);
        drain();

        // Randomized mix.
        for (int t = 0; t < 200; t++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom);
            case ($urandom_range(0, 6))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: a = 32'h8000_0000;
                3: b = 32'($urandom_range(1, 20));
                4: a = 32'($urandom_range(0, 300));
                default: ;
            endcase
            issue(a, b, s);
            if ($urandom_range(0, 1) == 1) begin
                drain();
            end else begin
                n = 0;
                while (!done && n < 100) begin
                    @(negedge clk);
                    n++;
                end
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        // Asynchronous reset in mid-operation.
        reg1_i = 32'd77;
        reg2_i = 32'd5;
        signed_op = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_result", result, 64'd0);
        chk("arst_busy", {63'd0, busy}, 64'd0);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
